// File: rtl/wishbone_register_slave.sv
// Wishbone register-file responder: CONTROL, STATUS, interrupt enable/status and scratch words,
// each access acknowledged after a fixed wait-state count, with a level interrupt from event edges.
module wishbone_register_slave #(
  parameter int unsigned ACK_LATENCY = 1,
  parameter int unsigned NUM_EVENTS  = 8,
  parameter int unsigned NUM_SCRATCH = 4,
  parameter logic [31:0] CTRL_RESET  = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_we_i,
  input  logic                  wb_msk_i,
  input  logic [3:0]            wb_sel_i,
  output logic                  wb_ack_o,
  output logic                  wb_int_o,
  input  logic [31:0]           status_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  output logic [31:0]           ctrl_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_DONE} state_t;

  state_t                 state_q;
  logic [3:0]             cnt_q;
  logic [31:0]            adr_q;
  logic [31:0]            wdat_q;
  logic                   we_q;
  logic [3:0]             sel_q;
  logic                   ack_q;
  logic [31:0]            rdat_q;
  logic                   int_q;
  logic [31:0]            ctrl_q;
  logic [NUM_EVENTS-1:0]  ien_q;
  logic [NUM_EVENTS-1:0]  ist_q;
  logic [NUM_EVENTS-1:0]  event_q;
  logic [31:0]            scratch_q [NUM_SCRATCH];

  logic [31:0]            bmask;
  logic [NUM_SCRATCH-1:0] scr_hit;
  logic                   hit_ctrl;
  logic                   hit_stat;
  logic                   hit_ien;
  logic                   hit_ist;
  logic                   commit;
  logic [31:0]            rdata_d;
  logic [31:0]            ctrl_d;
  logic [NUM_EVENTS-1:0]  ien_d;
  logic [NUM_EVENTS-1:0]  ist_d;
  logic [NUM_EVENTS-1:0]  w1c;
  logic [NUM_EVENTS-1:0]  ev_edge;
  logic                   unused_msk;

  assign unused_msk = wb_msk_i;

  for (genvar gi = 0; gi < 4; gi++) begin : g_bmask
    assign bmask[8*gi +: 8] = {8{sel_q[gi]}};
  end

  for (genvar gi = 0; gi < NUM_SCRATCH; gi++) begin : g_scr_hit
    assign scr_hit[gi] = (adr_q == 32'(4 + gi));
  end

  assign hit_ctrl = (adr_q == 32'd0);
  assign hit_stat = (adr_q == 32'd1);
  assign hit_ien  = (adr_q == 32'd2);
  assign hit_ist  = (adr_q == 32'd3);
  assign commit   = (state_q == S_ACK) && we_q;

  always_comb begin
    rdata_d = '0;
    if (hit_ctrl) rdata_d = ctrl_q;
    if (hit_stat) rdata_d = status_i;
    if (hit_ien)  rdata_d[NUM_EVENTS-1:0] = ien_q;
    if (hit_ist)  rdata_d[NUM_EVENTS-1:0] = ist_q;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (scr_hit[i]) rdata_d = scratch_q[i];
    end
  end

  // Event set is applied after the W1C clear so a coincident edge keeps its bit.
  assign ev_edge = event_i & ~event_q;
  assign w1c     = (commit && hit_ist) ? (wdat_q[NUM_EVENTS-1:0] & bmask[NUM_EVENTS-1:0]) : '0;
  assign ist_d   = (ist_q & ~w1c) | ev_edge;
  assign ctrl_d  = (commit && hit_ctrl) ? ((ctrl_q & ~bmask) | (wdat_q & bmask)) : ctrl_q;
  assign ien_d   = (commit && hit_ien)
                   ? ((ien_q & ~bmask[NUM_EVENTS-1:0]) | (wdat_q[NUM_EVENTS-1:0] & bmask[NUM_EVENTS-1:0]))
                   : ien_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= CTRL_RESET;
      ien_q   <= '0;
      ist_q   <= '0;
      event_q <= '0;
      int_q   <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      ien_q   <= ien_d;
      ist_q   <= ist_d;
      event_q <= event_i;
      int_q   <= |(ist_q & ien_q);
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (commit && scr_hit[i]) scratch_q[i] <= (scratch_q[i] & ~bmask) | (wdat_q & bmask);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ack_q <= 1'b0;
          if (wb_stb_i && wb_cyc_i) begin
            adr_q   <= wb_adr_i;
            wdat_q  <= wb_dat_i;
            we_q    <= wb_we_i;
            sel_q   <= wb_sel_i;
            cnt_q   <= 4'(ACK_LATENCY - 1);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!wb_cyc_i) begin
            state_q <= S_IDLE;
          end else if (cnt_q == 4'd0) begin
            ack_q   <= 1'b1;
            rdat_q  <= rdata_d;
            state_q <= S_ACK;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACK: begin
          ack_q   <= 1'b0;
          rdat_q  <= '0;
          state_q <= S_DONE;
        end
        S_DONE: begin
          ack_q <= 1'b0;
          // Wait for the master to release stb so one strobe is never serviced twice.
          if (!wb_stb_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = rdat_q;
  assign wb_int_o = int_q;
  assign ctrl_o   = ctrl_q;

endmodule

// File: tb/tb_wishbone_register_slave.sv
// Self-checking bench: two responders (ack latency 1 and 4) driven by directed and random
// Wishbone traffic, compared against a plain register-map model.
module tb_wishbone_register_slave;

  localparam int          NE    = 8;
  localparam int          NS    = 4;
  localparam logic [31:0] RST_A = 32'h0000_0000;
  localparam logic [31:0] RST_B = 32'hA5A5_0000;

  int unsigned lat_cfg [2] = '{1, 4};

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   adr, wdat, status;
  logic          we, msk;
  logic [3:0]    sel;
  logic          stb_a, stb_b, cyc_a, cyc_b;
  logic [NE-1:0] ev;
  logic          ack_a, ack_b, irq_a, irq_b;
  logic [31:0]   rdat_a, rdat_b, ctrl_a, ctrl_b;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_ctrl [2];
  logic [31:0] m_ien  [2];
  logic [31:0] m_ist  [2];
  logic [31:0] m_scr  [2][NS];

  always #5 clk = ~clk;

  wishbone_register_slave #(.ACK_LATENCY(1), .NUM_EVENTS(NE), .NUM_SCRATCH(NS), .CTRL_RESET(RST_A)) dut_a (
    .clk(clk), .rst(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat_a),
    .wb_stb_i(stb_a), .wb_cyc_i(cyc_a), .wb_we_i(we), .wb_msk_i(msk), .wb_sel_i(sel),
    .wb_ack_o(ack_a), .wb_int_o(irq_a), .status_i(status), .event_i(ev), .ctrl_o(ctrl_a));

  wishbone_register_slave #(.ACK_LATENCY(4), .NUM_EVENTS(NE), .NUM_SCRATCH(NS), .CTRL_RESET(RST_B)) dut_b (
    .clk(clk), .rst(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat_b),
    .wb_stb_i(stb_b), .wb_cyc_i(cyc_b), .wb_we_i(we), .wb_msk_i(msk), .wb_sel_i(sel),
    .wb_ack_o(ack_b), .wb_int_o(irq_b), .status_i(status), .event_i(ev), .ctrl_o(ctrl_b));

  function automatic logic get_ack(int w);
    return (w == 0) ? ack_a : ack_b;
  endfunction

  function automatic logic get_irq(int w);
    return (w == 0) ? irq_a : irq_b;
  endfunction

  function automatic logic [31:0] get_rdat(int w);
    return (w == 0) ? rdat_a : rdat_b;
  endfunction

  function automatic logic [31:0] get_ctrl(int w);
    return (w == 0) ? ctrl_a : ctrl_b;
  endfunction

  task automatic set_bus(input int w, input logic v);
    if (w == 0) begin stb_a = v; cyc_a = v; end
    else        begin stb_b = v; cyc_b = v; end
  endtask

  function automatic logic [31:0] byte_mask(logic [3:0] s);
    logic [31:0] m = '0;
    for (int b = 0; b < 4; b++) if (s[b]) m |= 32'hFF << (8 * b);
    return m;
  endfunction

  task automatic model_reset();
    m_ctrl[0] = RST_A;
    m_ctrl[1] = RST_B;
    for (int w = 0; w < 2; w++) begin
      m_ien[w] = '0;
      m_ist[w] = '0;
      for (int i = 0; i < NS; i++) m_scr[w][i] = '0;
    end
  endtask

  function automatic logic [31:0] model_read(int w, logic [31:0] a);
    int idx = int'(a) - 4;
    if (a == 32'd0) return m_ctrl[w];
    if (a == 32'd1) return status;
    if (a == 32'd2) return m_ien[w];
    if (a == 32'd3) return m_ist[w];
    if (a >= 32'd4 && a < 32'(4 + NS)) return m_scr[w][idx];
    return 32'h0;
  endfunction

  task automatic model_write(input int w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] bm = byte_mask(s);
    logic [31:0] evm = (32'h1 << NE) - 32'h1;
    int idx = int'(a) - 4;
    if (a == 32'd0) m_ctrl[w] = (m_ctrl[w] & ~bm) | (d & bm);
    else if (a == 32'd2) m_ien[w] = ((m_ien[w] & ~bm) | (d & bm)) & evm;
    else if (a == 32'd3) m_ist[w] = m_ist[w] & ~(d & bm);
    else if (a >= 32'd4 && a < 32'(4 + NS)) m_scr[w][idx] = (m_scr[w][idx] & ~bm) | (d & bm);
  endtask

  function automatic logic [31:0] model_irq(int w);
    return {31'd0, (m_ist[w] & m_ien[w]) != 32'd0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction; ev_on_ack rises so its edge lands on the write-commit edge.
  task automatic xfer(input int w, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [NE-1:0] ev_on_ack);
    logic [31:0] exp_rd = model_read(w, a);
    logic [31:0] rd = '0;
    bit seen = 0;
    int lat = -1;
    int acks = 0;
    adr = a; wdat = d; we = wr; sel = s;
    set_bus(w, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (get_ack(w)) begin seen = 1; lat = k - 1; rd = get_rdat(w); break; end
    end
    check("ack_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("latency", 32'(lat), 32'(lat_cfg[w]));
      if (!wr) check("rdata", rd, exp_rd);
      ev = ev_on_ack;
      @(posedge clk); #1;
      ev = '0;
      if (wr) model_write(w, a, d, s);
      for (int j = 0; j < 2; j++) m_ist[j] |= 32'(ev_on_ack);
      acks += int'(get_ack(w));
      repeat (2) begin @(posedge clk); #1; acks += int'(get_ack(w)); end
      check("single_ack", 32'(acks), 32'd0);
    end
    set_bus(w, 1'b0);
    @(posedge clk); #1;
    check("ctrl_o", get_ctrl(w), m_ctrl[w]);
    check("wb_int_o", 32'(get_irq(w)), model_irq(w));
    $display("xfer dut=%0d we=%0b adr=%h dat=%h sel=%b rd=%h lat=%0d", w, wr, a, d, s, rd, lat);
  endtask

  task automatic pulse_events(input logic [NE-1:0] bits);
    ev = bits;
    @(posedge clk); #1;
    ev = '0;
    @(posedge clk); #1;
    for (int j = 0; j < 2; j++) m_ist[j] |= 32'(bits);
    check("irq_a_after_event", 32'(irq_a), model_irq(0));
    check("irq_b_after_event", 32'(irq_b), model_irq(1));
    $display("events %b irq_a=%0b irq_b=%0b", bits, irq_a, irq_b);
  endtask

  initial begin
    int acks;
    logic [31:0] ra;
    logic [31:0] addr_tbl [10] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'h1F, 32'd0};

    rst = 1'b1; adr = '0; wdat = '0; we = 1'b0; msk = 1'b0; sel = '0;
    stb_a = 1'b0; stb_b = 1'b0; cyc_a = 1'b0; cyc_b = 1'b0; ev = '0;
    status = $urandom;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_ack_a", 32'(ack_a), 32'd0);
    check("reset_dat_a", rdat_a, 32'd0);
    check("reset_irq_a", 32'(irq_a), 32'd0);
    check("reset_ctrl_a", ctrl_a, RST_A);
    check("reset_ctrl_b", ctrl_b, RST_B);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full-word write and readback at latency 1
    xfer(0, 1'b1, 32'd0, 32'hDEADBEEF, 4'hF, '0);
    check("ctrl_deadbeef", ctrl_a, 32'hDEADBEEF);
    xfer(0, 1'b0, 32'd0, 32'h0, 4'hF, '0);

    // Partial byte write into scratch0
    xfer(0, 1'b1, 32'd4, 32'h11223344, 4'hF, '0);
    xfer(0, 1'b1, 32'd4, 32'hAABBCCDD, 4'b0101, '0);
    check("partial_model", m_scr[0][0], 32'h11BB33DD);
    xfer(0, 1'b0, 32'd4, 32'h0, 4'hF, '0);
    xfer(0, 1'b1, 32'd5, 32'h5555AAAA, 4'b0000, '0);
    xfer(0, 1'b0, 32'd5, 32'h0, 4'hF, '0);

    // Latency 4 with stb held, then abort by dropping cyc at E+2
    xfer(1, 1'b1, 32'd0, 32'hCAFEF00D, 4'hF, '0);
    adr = 32'd0; wdat = 32'h0BAD0BAD; we = 1'b1; sel = 4'hF;
    set_bus(1, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc_b = 1'b0;
    acks = 0;
    repeat (8) begin @(posedge clk); #1; acks += int'(ack_b); end
    stb_b = 1'b0;
    check("abort_no_ack", 32'(acks), 32'd0);
    check("abort_no_write", ctrl_b, m_ctrl[1]);
    $display("abort dut=1 acks=%0d ctrl=%h", acks, ctrl_b);
    @(posedge clk); #1;
    xfer(1, 1'b0, 32'd0, 32'h0, 4'hF, '0);

    // Interrupt set, W1C clear, and W1C racing a new edge
    xfer(0, 1'b1, 32'd2, 32'h01, 4'hF, '0);
    pulse_events(8'h01);
    check("irq_set", 32'(irq_a), 32'd1);
    xfer(0, 1'b0, 32'd3, 32'h0, 4'hF, '0);
    xfer(0, 1'b1, 32'd3, 32'h01, 4'hF, '0);
    check("irq_cleared", 32'(irq_a), 32'd0);
    xfer(0, 1'b1, 32'd3, 32'h01, 4'hF, 8'h01);
    check("set_wins", 32'(irq_a), 32'd1);
    xfer(0, 1'b0, 32'd3, 32'h0, 4'hF, '0);
    xfer(0, 1'b1, 32'd3, 32'h00FF0000, 4'b1110, '0);

    // Unmapped address
    xfer(0, 1'b0, 32'h1F, 32'h0, 4'hF, '0);
    xfer(0, 1'b1, 32'h1F, 32'hFFFFFFFF, 4'hF, '0);
    for (int i = 0; i < 8; i++) xfer(0, 1'b0, 32'(i), 32'h0, 4'hF, '0);

    // Random traffic on both responders
    for (int n = 0; n < 40; n++) begin
      int w = int'($urandom_range(0, 1));
      int pick = int'($urandom_range(0, 9));
      ra = (pick == 9) ? $urandom : addr_tbl[pick];
      if ($urandom_range(0, 7) == 0) status = $urandom;
      if ($urandom_range(0, 4) == 0) pulse_events(NE'($urandom));
      xfer(w, 1'($urandom), ra, $urandom, 4'($urandom),
           ($urandom_range(0, 5) == 0) ? NE'($urandom) : '0);
    end

    // Reset asserted mid-WAIT
    adr = 32'd0; wdat = 32'h12345678; we = 1'b1; sel = 4'hF;
    set_bus(1, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    check("async_rst_ctrl_b", ctrl_b, RST_B);
    check("async_rst_ack_b", 32'(ack_b), 32'd0);
    set_bus(1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    acks = 0;
    repeat (6) begin @(posedge clk); #1; acks += int'(ack_b); end
    check("rst_no_ack", 32'(acks), 32'd0);
    check("rst_ctrl_a", ctrl_a, RST_A);
    check("rst_ctrl_b", ctrl_b, RST_B);
    $display("reset mid-wait acks=%0d ctrl_b=%h", acks, ctrl_b);
    xfer(1, 1'b1, 32'd6, 32'h600DCAFE, 4'hF, '0);
    xfer(1, 1'b0, 32'd6, 32'h0, 4'hF, '0);
    xfer(0, 1'b0, 32'd2, 32'h0, 4'hF, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
